// File: rtl/aq_tape_pkg.sv
// Shared types and defaults for the Aquarius cassette capture engine.
// Holds the recorder state set, cycle classes and the cycle-length classifier.
package aq_tape_pkg;

   localparam int unsigned CNT_W          = 21;
   localparam int unsigned DEF_ADDR_W     = 16;
   localparam int unsigned DEF_MIN_CYCLE  = 300;
   localparam int unsigned DEF_SHORT_MAX  = 1100;
   localparam int unsigned DEF_LONG_MAX   = 2200;
   localparam int unsigned DEF_LEADER_MIN = 8;
   localparam int unsigned DEF_TIMEOUT    = 1_789_773;

   typedef enum logic [2:0] {
      IDLE,
      LEADER,
      DATA,
      STOP,
      SYNC,
      DONE
   } tape_rec_state_t;

   typedef enum logic [1:0] {
      GLITCH,
      ONE,
      ZERO,
      BREAK
   } cyc_class_t;

   // Map a measured cycle length (in ticks) onto its line-code meaning.
   function automatic cyc_class_t classify(input logic [CNT_W-1:0] len,
                                           input int unsigned      min_cycle,
                                           input int unsigned      short_max,
                                           input int unsigned      long_max);
      cyc_class_t cls;
      if (32'(len) < min_cycle)       cls = GLITCH;
      else if (32'(len) <= short_max) cls = ONE;
      else if (32'(len) <= long_max)  cls = ZERO;
      else                            cls = BREAK;
      return cls;
   endfunction

endpackage

// File: rtl/aq_tape_cycle_meter.sv
// Measures cassette cycle lengths between rising edges of the synchronised level
// and reports one classified cycle per accepted edge, plus a silence timeout level.
module aq_tape_cycle_meter
   import aq_tape_pkg::*;
#(
   parameter int unsigned MIN_CYCLE = DEF_MIN_CYCLE,
   parameter int unsigned SHORT_MAX = DEF_SHORT_MAX,
   parameter int unsigned LONG_MAX  = DEF_LONG_MAX,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce_tick,
   input  logic       cass_out,
   output logic       cyc_valid,
   output cyc_class_t cyc_class,
   output logic       timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   logic [2:0]       sync;
   logic             rise_c;
   logic             accept_c;
   logic [CNT_W-1:0] cnt;
   cyc_class_t       class_c;

   assign rise_c   = sync[1] & ~sync[2];
   assign class_c  = classify(cnt, MIN_CYCLE, SHORT_MAX, LONG_MAX);
   assign accept_c = rise_c && (class_c != GLITCH);

   // sync[1:0] is the 2-FF synchroniser, sync[2] the edge-detect history
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync <= '0;
      else          sync <= {sync[1:0], cass_out};
   end

   // Glitch edges leave the counter running so the real cycle is measured whole
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        cnt <= '0;
      else if (accept_c)                   cnt <= '0;
      else if (ce_tick && cnt != CNT_MAX)  cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_valid <= 1'b0;
         cyc_class <= GLITCH;
         timeout   <= 1'b0;
      end else begin
         cyc_valid <= accept_c;
         cyc_class <= class_c;
         timeout   <= (cnt >= TIMEOUT_CNT);
      end
   end

endmodule

// File: rtl/aq_tape_recorder.sv
// Cassette capture engine: decodes framed bytes from the CPU's cassette output
// and writes them sequentially into a capture RAM for later CAQ upload.
module aq_tape_recorder
   import aq_tape_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned MIN_CYCLE  = DEF_MIN_CYCLE,
   parameter int unsigned SHORT_MAX  = DEF_SHORT_MAX,
   parameter int unsigned LONG_MAX   = DEF_LONG_MAX,
   parameter int unsigned LEADER_MIN = DEF_LEADER_MIN,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce_tick,
   input  logic              cass_out,
   input  logic              arm,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [ADDR_W-1:0] length,
   output logic              recording,
   output logic              done,
   output logic              frame_err,
   output logic              overrun
);

   localparam int unsigned      RUN_W    = $clog2(LEADER_MIN + 2);
   localparam logic [RUN_W-1:0] RUN_MAX  = '1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   logic       cyc_valid;
   cyc_class_t cyc_class;
   logic       timeout;
   logic       bit_c;

   tape_rec_state_t   state, state_nxt;
   logic [RUN_W-1:0]  run_cnt, run_nxt;
   logic [6:0]        shreg, sh_nxt;
   logic [2:0]        bit_cnt, bit_nxt;
   logic              stop_cnt, stop_nxt;
   logic              wr_en_nxt, done_nxt, rec_nxt, fe_nxt, ov_nxt;
   logic [ADDR_W-1:0] addr_nxt, len_nxt;
   logic [7:0]        data_nxt;

   aq_tape_cycle_meter #(
      .MIN_CYCLE (MIN_CYCLE),
      .SHORT_MAX (SHORT_MAX),
      .LONG_MAX  (LONG_MAX),
      .TIMEOUT   (TIMEOUT)
   ) u_meter (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce_tick   (ce_tick),
      .cass_out  (cass_out),
      .cyc_valid (cyc_valid),
      .cyc_class (cyc_class),
      .timeout   (timeout)
   );

   assign bit_c = (cyc_class == ONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = run_cnt;
      sh_nxt    = shreg;
      bit_nxt   = bit_cnt;
      stop_nxt  = stop_cnt;
      wr_en_nxt = 1'b0;
      data_nxt  = wr_data;
      addr_nxt  = wr_addr;
      len_nxt   = length;
      fe_nxt    = frame_err;
      ov_nxt    = overrun;

      // Retire the write issued last clk; the top address never wraps
      if (wr_en) begin
         if (length != ADDR_MAX)  len_nxt = length + 1'b1;
         if (wr_addr == ADDR_MAX) ov_nxt = 1'b1;
         else                     addr_nxt = wr_addr + 1'b1;
      end

      case (state)
         IDLE: begin
            if (arm) begin
               state_nxt = LEADER;
               len_nxt   = '0;
               addr_nxt  = '0;
               fe_nxt    = 1'b0;
               ov_nxt    = 1'b0;
               run_nxt   = '0;
            end
         end
         DONE: begin
            if (!arm) state_nxt = IDLE;
         end
         default: begin
            if (!arm) begin
               state_nxt = DONE;
            end else if (wr_en && wr_addr == ADDR_MAX) begin
               state_nxt = DONE;
            end else if (timeout && length != '0) begin
               state_nxt = DONE;
            end else if (cyc_valid) begin
               case (state)
                  LEADER: begin
                     if (cyc_class == ONE) begin
                        if (run_cnt != RUN_MAX) run_nxt = run_cnt + 1'b1;
                     end else if (cyc_class == ZERO && 32'(run_cnt) >= LEADER_MIN) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                     end else begin
                        run_nxt = '0;
                     end
                  end
                  DATA: begin
                     if (cyc_class == BREAK) begin
                        state_nxt = LEADER;
                        run_nxt   = '0;
                     end else begin
                        sh_nxt  = {bit_c, shreg[6:1]};
                        bit_nxt = bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                           wr_en_nxt = 1'b1;
                           data_nxt  = {bit_c, shreg};
                           state_nxt = STOP;
                           stop_nxt  = 1'b0;
                        end
                     end
                  end
                  STOP: begin
                     if (cyc_class == BREAK) begin
                        state_nxt = LEADER;
                        run_nxt   = '0;
                     end else begin
                        if (cyc_class == ZERO) fe_nxt = 1'b1;
                        if (stop_cnt) state_nxt = SYNC;
                        else          stop_nxt  = 1'b1;
                     end
                  end
                  SYNC: begin
                     if (cyc_class == ZERO) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                     end else if (cyc_class == BREAK) begin
                        state_nxt = LEADER;
                        run_nxt   = '0;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase

      done_nxt = (state_nxt == DONE) && (state != DONE);
      rec_nxt  = (state_nxt != IDLE) && (state_nxt != DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_cnt   <= '0;
         shreg     <= '0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         length    <= '0;
         recording <= 1'b0;
         done      <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         run_cnt   <= run_nxt;
         shreg     <= sh_nxt;
         bit_cnt   <= bit_nxt;
         stop_cnt  <= stop_nxt;
         wr_en     <= wr_en_nxt;
         wr_addr   <= addr_nxt;
         wr_data   <= data_nxt;
         length    <= len_nxt;
         recording <= rec_nxt;
         done      <= done_nxt;
         frame_err <= fe_nxt;
         overrun   <= ov_nxt;
      end
   end

endmodule

// File: tb/tb_aq_tape_recorder.sv
// Directed bench for aq_tape_recorder: drives framed cassette waveforms and
// scores RAM writes against a queue of expected (addr, data) pairs.
`timescale 1ns/1ps
module tb_aq_tape_recorder;
   import aq_tape_pkg::*;

   localparam int unsigned T_MIN   = 6;
   localparam int unsigned T_SHORT = 22;
   localparam int unsigned T_LONG  = 44;
   localparam int unsigned T_LEAD  = 8;
   localparam int unsigned T_TO    = 200;
   localparam int P1 = 15;
   localparam int P0 = 30;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic ce_tick = 1'b1;
   logic cass_out = 1'b0;
   logic arm = 1'b0;
   logic arm_s = 1'b0;

   logic        wr_en, recording, done, frame_err, overrun;
   logic [15:0] wr_addr, length;
   logic [7:0]  wr_data;
   logic        wr_en_s, recording_s, done_s, frame_err_s, overrun_s;
   logic [3:0]  wr_addr_s, length_s;
   logic [7:0]  wr_data_s;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  exp_s[$];
   int   n_pass = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   done_cnt_s = 0;
   int   n_wr_s = 0;
   logic [3:0] last_addr_s = '0;

   always #5 clk = ~clk;

   aq_tape_recorder #(
      .ADDR_W(16), .MIN_CYCLE(T_MIN), .SHORT_MAX(T_SHORT), .LONG_MAX(T_LONG),
      .LEADER_MIN(T_LEAD), .TIMEOUT(T_TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ce_tick(ce_tick), .cass_out(cass_out), .arm(arm),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .length(length),
      .recording(recording), .done(done), .frame_err(frame_err), .overrun(overrun)
   );

   aq_tape_recorder #(
      .ADDR_W(4), .MIN_CYCLE(T_MIN), .SHORT_MAX(T_SHORT), .LONG_MAX(T_LONG),
      .LEADER_MIN(T_LEAD), .TIMEOUT(T_TO)
   ) dut_s (
      .clk(clk), .reset_n(reset_n), .ce_tick(ce_tick), .cass_out(cass_out), .arm(arm_s),
      .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s), .length(length_s),
      .recording(recording_s), .done(done_s), .frame_err(frame_err_s), .overrun(overrun_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard for the full-size recorder
   always @(negedge clk) begin : mon
      wr_t e;
      if (wr_en) begin
         if (exp_q.size() == 0) chk("spurious_wr", 32'(exp_q.size()), 32'd1);
         else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_data", 32'(wr_data), 32'(e.data));
         end
      end
      if (done) done_cnt++;
   end

   // Scoreboard for the 16-entry recorder
   always @(negedge clk) begin : mon_s
      wr_t e;
      if (wr_en_s) begin
         n_wr_s++;
         last_addr_s = wr_addr_s;
         if (exp_s.size() == 0) chk("spurious_wr_s", 32'(exp_s.size()), 32'd1);
         else begin
            e = exp_s.pop_front();
            chk("wr_addr_s", 32'(wr_addr_s), 32'(e.addr));
            chk("wr_data_s", 32'(wr_data_s), 32'(e.data));
         end
      end
      if (done_s) begin
         done_cnt_s++;
         chk("ovr_done_after_addr15", 32'(last_addr_s), 32'd15);
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic cyc(input int p, input bit g);
      cass_out = 1'b1;
      if (g) begin
         clks(2); cass_out = 1'b0;
         clks(1); cass_out = 1'b1;
         clks(p / 2 - 3);
      end else begin
         clks(p / 2);
      end
      cass_out = 1'b0;
      clks(p - p / 2);
   endtask

   task automatic send_bit(input bit b, input bit g = 1'b0);
      cyc(b ? P1 : P0, g);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit bad_stop = 1'b0, input bit g = 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i], g);
      send_bit(!bad_stop);
      send_bit(1'b1);
   endtask

   task automatic leader();
      repeat (10) send_bit(1'b1);
   endtask

   task automatic push(input int a, input logic [7:0] d);
      wr_t e;
      e.addr = 16'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Drop arm and expect an immediate single done pulse with length held
   task automatic end_take(input int exp_len);
      arm = 1'b0;
      clks(1);
      chk("done_pulse", 32'(done), 32'd1);
      chk("len_held", 32'(length), 32'(exp_len));
      clks(1);
      chk("done_single", 32'(done), 32'd0);
      chk("rec_after_done", 32'(recording), 32'd0);
      clks(2);
   endtask

   initial begin : stim
      int d0;
      wr_t e;
      logic [7:0] b;

      // Reset state
      clks(3);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_length", 32'(length), 32'd0);
      chk("rst_recording", 32'(recording), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      reset_n = 1'b1;
      cass_out = 1'b1;
      clks(3);

      // Take 1: leader then 0xA5
      arm = 1'b1;
      clks(3);
      chk("rec_on_arm", 32'(recording), 32'd1);
      leader();
      push(0, 8'hA5);
      send_byte(8'hA5);
      cass_out = 1'b1;
      clks(8);
      chk("t1_length", 32'(length), 32'd1);
      chk("t1_frame_err", 32'(frame_err), 32'd0);
      chk("t1_recording", 32'(recording), 32'd1);
      end_take(1);

      // Take 2: three bytes then silence until timeout
      arm = 1'b1;
      clks(3);
      chk("t2_len_cleared", 32'(length), 32'd0);
      d0 = done_cnt;
      leader();
      push(0, 8'h00); send_byte(8'h00);
      push(1, 8'hFF); send_byte(8'hFF);
      push(2, 8'h3C); send_byte(8'h3C);
      send_bit(1'b1);
      cass_out = 1'b1;
      for (int i = 0; i < 400 && !done; i++) clks(1);
      chk("t2_timeout_done", 32'(done), 32'd1);
      chk("t2_length", 32'(length), 32'd3);
      clks(3);
      chk("t2_recording", 32'(recording), 32'd0);
      chk("t2_done_count", 32'(done_cnt - d0), 32'd1);
      arm = 1'b0;
      clks(3);

      // Take 3: glitches inside data bits
      arm = 1'b1;
      clks(2);
      leader();
      push(0, 8'h5A);
      send_byte(8'h5A, 1'b0, 1'b1);
      cass_out = 1'b1;
      clks(8);
      chk("t3_length", 32'(length), 32'd1);
      end_take(1);

      // Take 4: bad first stop bit, byte kept; next byte follows at addr 1
      arm = 1'b1;
      clks(2);
      leader();
      push(0, 8'h11);
      send_byte(8'h11, 1'b1);
      chk("t4_frame_err", 32'(frame_err), 32'd1);
      push(1, 8'h77);
      send_byte(8'h77);
      cass_out = 1'b1;
      clks(8);
      chk("t4_length", 32'(length), 32'd2);
      chk("t4_frame_err_sticky", 32'(frame_err), 32'd1);
      end_take(2);

      // Take 5: arm drops midway through data bit 4
      arm = 1'b1;
      clks(2);
      leader();
      push(0, 8'h3C);
      send_byte(8'h3C);
      send_bit(1'b0);
      b = 8'hE7;
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      cass_out = 1'b1;
      clks(3);
      end_take(1);
      repeat (4) send_bit(1'b1);
      cass_out = 1'b1;
      clks(4);

      // Take 6: reset mid-byte
      arm = 1'b1;
      clks(2);
      leader();
      push(0, 8'hC3);
      send_byte(8'hC3);
      send_bit(1'b0);
      send_bit(1'b1);
      cass_out = 1'b1;
      clks(2);
      chk("t6_pre_rec", 32'(recording), 32'd1);
      chk("t6_pre_len", 32'(length), 32'd1);
      d0 = done_cnt;
      reset_n = 1'b0;
      #1;
      chk("t6_wr_en", 32'(wr_en), 32'd0);
      chk("t6_wr_addr", 32'(wr_addr), 32'd0);
      chk("t6_wr_data", 32'(wr_data), 32'd0);
      chk("t6_length", 32'(length), 32'd0);
      chk("t6_recording", 32'(recording), 32'd0);
      chk("t6_frame_err", 32'(frame_err), 32'd0);
      chk("t6_overrun", 32'(overrun), 32'd0);
      clks(3);
      chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
      arm = 1'b0;
      reset_n = 1'b1;
      clks(3);

      // Small RAM: 17 bytes into 16 entries
      arm_s = 1'b1;
      clks(2);
      leader();
      for (int i = 0; i < 17; i++) begin
         b = 8'(i * 37 + 5);
         if (i < 16) begin
            e.addr = 16'(i);
            e.data = b;
            exp_s.push_back(e);
         end
         send_byte(b);
      end
      cass_out = 1'b1;
      clks(10);
      chk("s_overrun", 32'(overrun_s), 32'd1);
      chk("s_done_count", 32'(done_cnt_s), 32'd1);
      chk("s_recording", 32'(recording_s), 32'd0);
      chk("s_wr_addr_held", 32'(wr_addr_s), 32'd15);
      chk("s_write_count", 32'(n_wr_s), 32'd16);
      arm_s = 1'b0;
      clks(3);

      chk("main_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("small_queue_drained", 32'(exp_s.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/aq_tape_recorder.md
# aq_tape_recorder

Cassette capture engine for the Aquarius core, the recording-side counterpart of the tape player. Decodes the CPU's cassette output level into bytes and writes them sequentially into a capture RAM, so a saved program can be uploaded to the host as a CAQ image. It sits between the PLA's `CASS_OUT` and a `gen_dpram` port, clocked from `clk_sys`.

## Interface

Parameters:
- `ADDR_W`, 16: capture RAM address width.
- `MIN_CYCLE`, 300: cycles shorter than this many ticks are glitches and are ignored.
- `SHORT_MAX`, 1100: cycle of at most this many ticks is a short cycle, bit 1.
- `LONG_MAX`, 2200: cycle of at most this many ticks is a long cycle, bit 0. Anything longer is a break.
- `LEADER_MIN`, 8: consecutive 1-cycles needed before a start bit is accepted.
- `TIMEOUT`, 1_789_773: ticks without a rising edge that end a recording (about 1 s).

Ports:
- `clk` in 1: system clock (`clk_sys`).
- `reset_n` in 1: asynchronous, active-low reset.
- `ce_tick` in 1: measurement tick enable (the 1.79 MHz `ce_1m7` strobe).
- `cass_out` in 1: raw cassette output level from the PLA.
- `arm` in 1: level. Recording is enabled while high.
- `wr_en` out 1: one-clk write strobe to the capture RAM.
- `wr_addr` out ADDR_W: write address.
- `wr_data` out 8: decoded byte.
- `length` out ADDR_W: number of bytes written in the current or last take.
- `recording` out 1: high while in any state other than IDLE or DONE.
- `done` out 1: one-clk pulse when a take ends.
- `frame_err` out 1: sticky. Set when a stop bit is received as 0.
- `overrun` out 1: sticky. Set when the RAM fills.

## Operation

- Line coding: one bit per full cycle, measured between rising edges. Short cycle = 1, long cycle = 0.
- Frame: start bit 0, 8 data bits LSB first, 2 stop bits 1. The idle leader is a run of 1s.
- Input path: `cass_out` passes through a 2-FF synchronizer, then a rising-edge detector.
- Cycle counter:
  - Increments on `ce_tick` and saturates at 2^21-1.
  - On a rising edge, the pre-increment value is the cycle length. The counter then restarts at 0.
  - A tick on the same clk as the edge is not counted into either cycle.
  - A cycle below `MIN_CYCLE` is discarded: no state change, and the counter keeps accumulating.
- States:
  - IDLE: outputs quiescent. On `arm`=1: clear `length`, `wr_addr`, `frame_err`, `overrun`, reset the run counter, go to LEADER.
  - LEADER: count consecutive 1-cycles. A 0-cycle with count ≥ `LEADER_MIN` goes to DATA. A 0-cycle with count below that resets the count.
  - DATA: shift 8 bits. When the 8th bit is classified, write the byte at `wr_addr`, then increment `wr_addr` and `length`. Go to STOP.
  - STOP: take 2 bits. A 0 sets `frame_err`; the byte is kept. Then go to SYNC.
  - SYNC: 1-cycles are idle and keep the state in SYNC. A 0-cycle is a start bit and goes to DATA.
  - DONE: `done` pulses on entry and `length` holds. `arm`=0 goes to IDLE; `arm` must be low for at least one clk before a new take.
- Break cycle (> `LONG_MAX`) in DATA or STOP: drop the partial byte and go to LEADER with the run count at 0.
- Timeout: counter reaches `TIMEOUT` in LEADER, DATA, STOP or SYNC with `length`>0 → DONE. With `length`=0, keep waiting.
- Memory full: after writing address 2^ADDR_W-1, set `overrun` and go to DONE. No address wrap.
- `arm` falls while recording: next clk go to DONE, `done` pulses, `length` is preserved, and any partial byte is discarded. `arm` falling in DONE goes to IDLE.

## Timing

- Reset: all outputs 0, state IDLE, counters 0.
- Latency: `wr_en` is high exactly 4 clk after the `cass_out` rising edge that ends data bit 7. `wr_data` and `wr_addr` are valid in the same clk as `wr_en`.
- `done` is a single clk pulse.
- `length` updates the clk after `wr_en`.
- `reset_n` asserted mid-take: immediate return to reset values. No `done` pulse.
- Back-to-back bytes are separated by at least 3 cycles (2 stop bits + start bit), so there is no write contention.

## Structure

- Package `aq_tape_pkg`:
  - state enum `tape_rec_state_t` (IDLE, LEADER, DATA, STOP, SYNC, DONE);
  - cycle class enum (GLITCH, ONE, ZERO, BREAK);
  - default threshold constants;
  - counter width 21.
- Sub-module `aq_tape_cycle_meter`: synchronizer, edge detect, saturating counter and classifier. It outputs a one-clk `cyc_valid` with `cyc_class`, plus a `timeout` level.

## Test plan

- Leader of 10 short cycles (746 ticks), then byte 0xA5 framed correctly → one `wr_en` at addr 0 with data 0xA5, `length`=1, `frame_err`=0.
- Three bytes 0x00, 0xFF, 0x3C, then silence for `TIMEOUT` ticks → writes at addr 0..2, `done` pulses once, `recording`=0, `length`=3.
- 200-tick glitch pulses injected inside data bits of 0x5A → byte still decodes as 0x5A.
- Byte 0x11 with first stop bit long → byte written, `frame_err`=1. Next good byte is written at addr 1.
- `ADDR_W`=4, stream of 17 bytes → 16 writes, `overrun`=1, `done` pulses after the write to addr 15, the 17th byte is not written.
- `arm` dropped midway through data bit 4 → `done` pulses the next clk, `length` is unchanged, no write. `reset_n` low mid-byte → all outputs 0, no `done`.
